clock_time_ctrl: RTL and testbench

- Mode/sequencing controller for the digital-clock datapath of three 8-bit 8421-BCD counters: seconds (mod 60), minutes (mod 60) and hours (mod 24), each with an `en` input.
- In run mode it turns the 1 Hz tick into cascaded enables, with carries decoded from the counters' BCD values.
- In set mode it freezes timekeeping and routes user increment-key pulses to the hour or minute counter.
- It also drives digit-blink gating for the display.

---
 rtl/clock_time_ctrl_if.sv | 28 ++
 rtl/clock_time_ctrl.sv | 129 ++++++++++++
 tb/tb_clock_time_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/clock_time_ctrl_if.sv
// Bundle between the digital-clock mode controller and the rest of the clock:
// key/tick pulses and BCD counter values in, counter enables and display gating out.
interface clock_time_ctrl_if;
    logic       tick_1hz;
    logic       key_mode;
    logic       key_inc;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hour_bcd;
    logic       sec_en;
    logic       min_en;
    logic       hour_en;
    logic [1:0] mode;
    logic       disp_hour_on;
    logic       disp_min_on;

    // Driver side: produces ticks, keys and counter values, consumes the controls.
    modport master (
        output tick_1hz, key_mode, key_inc, sec_bcd, min_bcd, hour_bcd,
        input  sec_en, min_en, hour_en, mode, disp_hour_on, disp_min_on
    );

    // Controller side.
    modport slave (
        input  tick_1hz, key_mode, key_inc, sec_bcd, min_bcd, hour_bcd,
        output sec_en, min_en, hour_en, mode, disp_hour_on, disp_min_on
    );
endinterface

// File: rtl/clock_time_ctrl.sv
// Mode/sequencing controller for a BCD digital clock (sec mod 60, min mod 60,
// hour mod 24). RUN cascades the 1 Hz tick into counter enables; SET_HOUR and
// SET_MIN freeze time and steer the increment key to one counter, blinking the
// selected digits and falling back to RUN after TIMEOUT_S idle seconds.
module clock_time_ctrl #(
    parameter int TIMEOUT_S = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    clock_time_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_SET_HOUR = 2'b01;
    localparam logic [1:0] ST_SET_MIN  = 2'b10;

    // A zero timeout still needs a 1-bit counter so the logic stays well formed.
    localparam int                IDLE_W     = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX   = '1;
    localparam logic [IDLE_W-1:0] TIMEOUT_V  = IDLE_W'(TIMEOUT_S);
    localparam bit                TIMEOUT_ON = (TIMEOUT_S > 0);

    logic [1:0]        state_q, state_d;
    logic              blink_q, blink_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [IDLE_W-1:0] idle_inc;
    logic              sec_en_q, sec_en_d;
    logic              min_en_q, min_en_d;
    logic              hour_en_q, hour_en_d;
    logic              disp_hour_q, disp_hour_d;
    logic              disp_min_q, disp_min_d;
    logic              carry_sec;
    logic              carry_min;
    logic              timeout_hit;
    logic              unused_hour;

    // Hours are status only; nothing is decoded from them.
    assign unused_hour = ^bus.hour_bcd;

    // Carries need an exact BCD 59, so garbage codes never ripple upward.
    assign carry_sec   = (bus.sec_bcd == 8'h59);
    assign carry_min   = carry_sec && (bus.min_bcd == 8'h59);
    assign idle_inc    = (idle_q == IDLE_MAX) ? idle_q : idle_q + IDLE_W'(1);
    assign timeout_hit = TIMEOUT_ON && (idle_inc == TIMEOUT_V);

    // Next-state decode: enables come from the current state, then any state change clears blink/idle.
    always_comb begin
        state_d   = state_q;
        blink_d   = blink_q;
        idle_d    = idle_q;
        sec_en_d  = 1'b0;
        min_en_d  = 1'b0;
        hour_en_d = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus.tick_1hz) begin
                    sec_en_d  = 1'b1;
                    min_en_d  = carry_sec;
                    hour_en_d = carry_min;
                end
                if (bus.key_mode) begin
                    state_d = ST_SET_HOUR;
                end
            end
            ST_SET_HOUR, ST_SET_MIN: begin
                if (bus.key_mode) begin
                    state_d = (state_q == ST_SET_HOUR) ? ST_SET_MIN : ST_RUN;
                end else if (bus.key_inc) begin
                    if (state_q == ST_SET_HOUR) begin
                        hour_en_d = 1'b1;
                    end else begin
                        min_en_d = 1'b1;
                    end
                    blink_d = 1'b0;
                    idle_d  = '0;
                end else if (bus.tick_1hz) begin
                    blink_d = !blink_q;
                    idle_d  = idle_inc;
                    if (timeout_hit) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (state_d != state_q) begin
            blink_d = 1'b0;
            idle_d  = '0;
        end

        disp_hour_d = !((state_d == ST_SET_HOUR) && blink_d);
        disp_min_d  = !((state_d == ST_SET_MIN) && blink_d);
    end

    // State and registered outputs, cleared asynchronously to a quiet RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            blink_q     <= 1'b0;
            idle_q      <= '0;
            sec_en_q    <= 1'b0;
            min_en_q    <= 1'b0;
            hour_en_q   <= 1'b0;
            disp_hour_q <= 1'b1;
            disp_min_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            blink_q     <= blink_d;
            idle_q      <= idle_d;
            sec_en_q    <= sec_en_d;
            min_en_q    <= min_en_d;
            hour_en_q   <= hour_en_d;
            disp_hour_q <= disp_hour_d;
            disp_min_q  <= disp_min_d;
        end
    end

    assign bus.sec_en       = sec_en_q;
    assign bus.min_en       = min_en_q;
    assign bus.hour_en      = hour_en_q;
    assign bus.mode         = state_q;
    assign bus.disp_hour_on = disp_hour_q;
    assign bus.disp_min_on  = disp_min_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl (TIMEOUT_S = 3): a table of single-cycle
// vectors with hand-computed outputs, plus hand-written reset sequences.
// Expected word layout: {sec_en, min_en, hour_en, mode[1:0], disp_hour_on, disp_min_on}.
module tb_clock_time_ctrl;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   passCount;

    clock_time_ctrl_if bus();

    clock_time_ctrl #(.TIMEOUT_S(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       tick;
        logic       keyMode;
        logic       keyInc;
        logic [7:0] sec;
        logic [7:0] min;
        logic [6:0] exp;
    } vec_t;

    vec_t vq[$];

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic t, input logic km, input logic ki,
                          input logic [7:0] s, input logic [7:0] m, input logic [6:0] e);
        vec_t v;
        v.tick    = t;
        v.keyMode = km;
        v.keyInc  = ki;
        v.sec     = s;
        v.min     = m;
        v.exp     = e;
        vq.push_back(v);
    endtask

    // Drive one cycle of inputs, let the DUT sample them, then drop the pulses.
    task automatic applyStimulus(input logic t, input logic km, input logic ki,
                                 input logic [7:0] s, input logic [7:0] m);
        bus.tick_1hz = t;
        bus.key_mode = km;
        bus.key_inc  = ki;
        bus.sec_bcd  = s;
        bus.min_bcd  = m;
        @(posedge clk);
        #1;
        bus.tick_1hz = 1'b0;
        bus.key_mode = 1'b0;
        bus.key_inc  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [6:0] expected);
        logic [6:0] got;
        got = {bus.sec_en, bus.min_en, bus.hour_en, bus.mode, bus.disp_hour_on, bus.disp_min_on};
        checkCount++;
        if (got === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %b, expected %b (sec_en,min_en,hour_en,mode,dh,dm)",
                     name, got, expected);
        end
    endtask

    initial begin
        checkCount   = 0;
        passCount    = 0;
        rst_n        = 1'b0;
        bus.tick_1hz = 1'b0;
        bus.key_mode = 1'b0;
        bus.key_inc  = 1'b0;
        bus.sec_bcd  = 8'h00;
        bus.min_bcd  = 8'h00;
        bus.hour_bcd = 8'h12;

        //         tick km ki sec    min    {s m h mode dh dm}
        // RUN cascade and carry decode
        addVec(1, 0, 0, 8'h58, 8'h00, 7'b1_0_0_00_1_1);
        addVec(0, 0, 0, 8'h58, 8'h00, 7'b0_0_0_00_1_1);
        addVec(1, 0, 0, 8'h59, 8'h59, 7'b1_1_1_00_1_1);
        addVec(0, 0, 0, 8'h59, 8'h59, 7'b0_0_0_00_1_1);
        addVec(1, 0, 0, 8'h59, 8'h58, 7'b1_1_0_00_1_1);
        addVec(1, 0, 0, 8'h5A, 8'h59, 7'b1_0_0_00_1_1);
        addVec(1, 0, 0, 8'h59, 8'h5A, 7'b1_1_0_00_1_1);
        addVec(0, 0, 1, 8'h00, 8'h00, 7'b0_0_0_00_1_1);
        // SET_HOUR: increments, frozen ticks, blink
        addVec(0, 1, 0, 8'h00, 8'h00, 7'b0_0_0_01_1_1);
        addVec(0, 0, 1, 8'h00, 8'h00, 7'b0_0_1_01_1_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_01_0_1);
        addVec(0, 0, 1, 8'h00, 8'h00, 7'b0_0_1_01_1_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_01_0_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_01_1_1);
        addVec(0, 0, 1, 8'h00, 8'h00, 7'b0_0_1_01_1_1);
        addVec(1, 0, 1, 8'h00, 8'h00, 7'b0_0_1_01_1_1);
        // mode + inc together: mode wins
        addVec(0, 1, 1, 8'h00, 8'h00, 7'b0_0_0_10_1_1);
        // SET_MIN: no carry into hours
        addVec(0, 0, 1, 8'h00, 8'h59, 7'b0_1_0_10_1_1);
        addVec(1, 0, 0, 8'h59, 8'h59, 7'b0_0_0_10_1_0);
        addVec(1, 1, 0, 8'h59, 8'h59, 7'b0_0_0_00_1_1);
        // RUN: tick and mode together still issue the tick's enables
        addVec(1, 1, 0, 8'h59, 8'h59, 7'b1_1_1_01_1_1);
        addVec(0, 1, 0, 8'h00, 8'h00, 7'b0_0_0_10_1_1);
        addVec(0, 1, 0, 8'h00, 8'h00, 7'b0_0_0_00_1_1);
        // Timeout after 3 idle ticks in SET_HOUR
        addVec(0, 1, 0, 8'h00, 8'h00, 7'b0_0_0_01_1_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_01_0_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_01_1_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_00_1_1);
        // key_inc between ticks 2 and 3 restarts the count
        addVec(0, 1, 0, 8'h00, 8'h00, 7'b0_0_0_01_1_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_01_0_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_01_1_1);
        addVec(0, 0, 1, 8'h00, 8'h00, 7'b0_0_1_01_1_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_01_0_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_01_1_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_00_1_1);
        // key_inc on the would-be timeout tick is honoured and cancels it
        addVec(0, 1, 0, 8'h00, 8'h00, 7'b0_0_0_01_1_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_01_0_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_01_1_1);
        addVec(1, 0, 1, 8'h00, 8'h00, 7'b0_0_1_01_1_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_01_0_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_01_1_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_00_1_1);
        // Timeout from SET_MIN
        addVec(0, 1, 0, 8'h00, 8'h00, 7'b0_0_0_01_1_1);
        addVec(0, 1, 0, 8'h00, 8'h00, 7'b0_0_0_10_1_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_10_1_0);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_10_1_1);
        addVec(1, 0, 0, 8'h00, 8'h00, 7'b0_0_0_00_1_1);

        // Reset held, then released with no stimulus for 10 cycles
        repeat (3) @(posedge clk);
        #1;
        checkOutput("in_reset", 7'b0_0_0_00_1_1);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            checkOutput($sformatf("idle_after_reset%0d", i), 7'b0_0_0_00_1_1);
        end

        foreach (vq[i]) begin
            applyStimulus(vq[i].tick, vq[i].keyMode, vq[i].keyInc, vq[i].sec, vq[i].min);
            checkOutput($sformatf("vec%0d", i), vq[i].exp);
        end

        // Asynchronous reset in the middle of SET_MIN with keys pending
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("pre_reset_set_min", 7'b0_0_0_10_1_1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h59, 8'h59);
        checkOutput("pre_reset_blink", 7'b0_0_0_10_1_0);
        #2;
        bus.key_inc  = 1'b1;
        bus.tick_1hz = 1'b1;
        rst_n        = 1'b0;
        #1;
        checkOutput("async_reset", 7'b0_0_0_00_1_1);
        @(posedge clk);
        #1;
        checkOutput("reset_held", 7'b0_0_0_00_1_1);
        bus.key_inc  = 1'b0;
        bus.tick_1hz = 1'b0;
        rst_n        = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h59, 8'h59);
            checkOutput($sformatf("after_release%0d", i), 7'b0_0_0_00_1_1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h59, 8'h59);
        checkOutput("run_after_release", 7'b1_1_1_00_1_1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
